// File: rtl/mem_arbiter.sv
// Two-master arbiter for a single-ported data memory: round-robin between the core (m0)
// and a loader/DMA (m1), with a bounded m1 lock and one-cycle read-return routing.
module mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_lock,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              s_en,
  output logic              s_we,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  input  logic [DATA_W-1:0] s_rdata,
  output logic              stall_core
);

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_state_t;

  localparam logic [7:0] LOCK_MAX_C = 8'(LOCK_MAX);

  lock_state_t state_q, state_d;
  logic [7:0]  lock_cnt_q, lock_cnt_d;
  logic        prio_q, prio_d;        // 0 = m0 preferred, 1 = m1 preferred
  logic        rd_pend_q, rd_pend_d;
  logic        rd_owner_q, rd_owner_d; // 1 = read belongs to m1
  logic        forced_rel;

  assign forced_rel = (state_q == LOCKED) && (lock_cnt_q >= LOCK_MAX_C);

  // Grant selection; nothing is granted while reset is held.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (rst_n) begin
      if (forced_rel) begin
        if (m0_req)      m0_gnt = 1'b1;
        else if (m1_req) m1_gnt = 1'b1;
      end else if (state_q == LOCKED) begin
        if (m1_req)      m1_gnt = 1'b1;
        else if (m0_req) m0_gnt = 1'b1;
      end else if (m0_req && m1_req) begin
        if (prio_q) m1_gnt = 1'b1;
        else        m0_gnt = 1'b1;
      end else if (m0_req) begin
        m0_gnt = 1'b1;
      end else if (m1_req) begin
        m1_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    s_en    = m0_gnt | m1_gnt;
    s_we    = 1'b0;
    s_addr  = '0;
    s_wdata = '0;
    if (m0_gnt) begin
      s_we    = m0_we;
      s_addr  = m0_addr;
      s_wdata = m0_wdata;
    end else if (m1_gnt) begin
      s_we    = m1_we;
      s_addr  = m1_addr;
      s_wdata = m1_wdata;
    end
  end

  assign stall_core = m0_req & ~m0_gnt;

  // Next-state for round-robin pointer, lock FSM and read-return tracking.
  always_comb begin
    prio_d     = prio_q;
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    rd_pend_d  = s_en & ~s_we;
    rd_owner_d = m1_gnt;

    if (m0_gnt)      prio_d = 1'b1;
    else if (m1_gnt) prio_d = 1'b0;

    case (state_q)
      UNLOCKED: begin
        if (m1_gnt && m1_lock) begin
          state_d    = LOCKED;
          lock_cnt_d = 8'd0;
        end
      end
      LOCKED: begin
        // A forced release always drops to UNLOCKED; m1 relocks on its next grant.
        if (forced_rel || !m1_lock || !m1_req) begin
          state_d    = UNLOCKED;
          lock_cnt_d = 8'd0;
        end else if (m0_req && m1_gnt) begin
          lock_cnt_d = lock_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d    = UNLOCKED;
        lock_cnt_d = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio_q     <= 1'b0;
      state_q    <= UNLOCKED;
      lock_cnt_q <= 8'd0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
    end else begin
      prio_q     <= prio_d;
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  // Gating with rst_n drops a read that was in flight when reset arrived.
  assign m0_rvalid = rst_n & rd_pend_q & ~rd_owner_q;
  assign m1_rvalid = rst_n & rd_pend_q &  rd_owner_q;
  assign m0_rdata  = m0_rvalid ? s_rdata : '0;
  assign m1_rdata  = m1_rvalid ? s_rdata : '0;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
  ADDR_W, 32, address width
  DATA_W, 32, data width
  LOCK_MAX, 8, max consecutive cycles m1 may hold a lock while m0 waits (2..255)
REQ-002 Ports SHALL be, one per line:
  clk  in  1  single clock; all logic on rising edge
  rst_n  in  1  synchronous reset, active-low
  m0_req  in  1  core data-port request (from EX/MEM stage)
  m0_we  in  1  m0 write enable
  m0_addr  in  ADDR_W  m0 byte address
  m0_wdata  in  DATA_W  m0 write data
  m0_gnt  out  1  m0 command accepted this cycle
  m0_rvalid  out  1  m0 read data valid
  m0_rdata  out  DATA_W  m0 read data
  m1_req  in  1  loader/DMA request
  m1_we  in  1  m1 write enable
  m1_addr  in  ADDR_W  m1 byte address
  m1_wdata  in  DATA_W  m1 write data
  m1_lock  in  1  m1 requests back-to-back ownership
  m1_gnt  out  1  m1 command accepted this cycle
  m1_rvalid  out  1  m1 read data valid
  m1_rdata  out  DATA_W  m1 read data
  s_en  out  1  slave (DataMem/MMU) access strobe
  s_we  out  1  slave write enable
  s_addr  out  ADDR_W  slave address
  s_wdata  out  DATA_W  slave write data
  s_rdata  in  DATA_W  slave read data, valid exactly 1 cycle after a read strobe
  stall_core  out  1  m0_req high and m0_gnt low (feeds hazard unit as a freeze)
REQ-003 clk and rst_n SHALL be the only clock and reset: one clock; reset synchronous and active-low.

Function
REQ-004 Arbitration SHALL be combinational within a cycle: at most one of m0_gnt/m1_gnt high; a grant only when the corresponding req is high.
REQ-005 s_en SHALL equal m0_gnt|m1_gnt; s_we/s_addr/s_wdata SHALL be muxed from the granted master, and SHALL be 0 when no grant.
REQ-006 Round-robin: a 1-bit pointer prio SHALL name the preferred master; if both request and no lock is active, grant prio; after any grant, prio SHALL become the non-granted master; a sole requester SHALL always be granted.
REQ-007 Lock FSM states SHALL be UNLOCKED and LOCKED; UNLOCKED->LOCKED when m1 is granted with m1_lock=1; LOCKED->UNLOCKED when m1_lock=0, m1_req=0, or forced release.
REQ-008 In LOCKED, m1 SHALL win over m0 regardless of prio; an 8-bit counter lock_cnt SHALL increment each LOCKED cycle with m0_req high and m1 granted, and reset to 0 on entering LOCKED.
REQ-009 When lock_cnt reaches LOCK_MAX, the next cycle SHALL grant m0 if m0_req is high (forced release), return to UNLOCKED and clear lock_cnt; m1 may relock on a subsequent grant.
REQ-010 Read return: a registered owner tag and pending flag SHALL be captured on each read grant (s_en & ~s_we); next cycle the owner's rvalid SHALL pulse for exactly 1 cycle with rdata = s_rdata; the other master's rvalid SHALL be 0.
REQ-011 mX_rdata SHALL be s_rdata whenever mX_rvalid is high, else 0.
REQ-012 Back-to-back reads from alternating masters SHALL be sustained at 1 grant/cycle with correct per-cycle rvalid routing.
REQ-013 Writes SHALL produce no rvalid.
REQ-014 stall_core SHALL be combinational: m0_req & ~m0_gnt.

Reset
REQ-015 While rst_n=0 at a clock edge: prio=m0, state=UNLOCKED, lock_cnt=0, read pending=0; m0_rvalid=m1_rvalid=0 from the following cycle.
REQ-016 Reset asserted with a read pending SHALL drop that read's rvalid; no rvalid SHALL appear after reset deasserts until a new read grant.
REQ-017 Grants during rst_n=0 SHALL be forced to 0 (s_en=0).

Verification
REQ-018 Single m0 read addr 0x80000010, s_rdata=0xDEADBEEF next cycle -> m0_gnt cycle 0, m0_rvalid=1 with 0xDEADBEEF cycle 1, m1_rvalid=0.
REQ-019 Both request reads continuously after reset, no lock -> grants alternate m0,m1,m0,m1; stall_core high on m1-grant cycles.
REQ-020 m1_lock=1 and m1_req held, m0_req held, LOCK_MAX=8 -> m1 granted 8 consecutive LOCKED cycles, then m0 granted once, then m1 relocks.
REQ-021 m1 write 0x10000008 data 0x41 while m0 idle -> s_en=1, s_we=1, s_addr=0x10000008, s_wdata=0x41; no rvalid next cycle.
REQ-022 m0 read granted, rst_n=0 next edge -> no m0_rvalid; after release prio=m0, both requesting -> m0 granted first.
